// File: rtl/data_sram_ctrl_pkg.sv
// Shared encodings for the MEM-stage data SRAM controller: access codes,
// bus size codes and controller state encoding.
package data_sram_ctrl_pkg;

   localparam logic [3:0] OP_LD_B = 4'b0000;
   localparam logic [3:0] OP_LD_H = 4'b0001;
   localparam logic [3:0] OP_LD_W = 4'b0010;
   localparam logic [3:0] OP_ST_B = 4'b0100;
   localparam logic [3:0] OP_ST_H = 4'b0101;
   localparam logic [3:0] OP_ST_W = 4'b0110;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_REQ  = 2'b01;
   localparam logic [1:0] ST_WAIT = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_LD_B, OP_LD_H, OP_LD_W, OP_ST_B, OP_ST_H, OP_ST_W: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// MEM-stage data SRAM bus controller: issues one request per instruction,
// tracks the response, and discards responses owed to flushed instructions.
module data_sram_ctrl
   import data_sram_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        ms_valid,
   input  logic        ms_ex,
   input  logic [3:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wb_allow_in,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        ms_ready_go,
   output logic [31:0] ms_rdata
);

   logic [1:0]  state_q, state_d;
   logic        discard_q, discard_d;
   logic [31:0] rdata_buf_q, rdata_buf_d;
   logic        access_needed;
   logic        issue;

   assign access_needed = ms_valid && op_legal(mem_op) && !ms_ex && !flush;
   assign issue         = access_needed && (state_q == ST_IDLE) && !discard_q;

   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      rdata_buf_d = rdata_buf_q;
      // A pending discard absorbs the very next response; a kill in the same
      // cycle re-arms it below.
      if (data_sram_data_ok) discard_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (issue) state_d = data_sram_addr_ok ? ST_WAIT : ST_REQ;
         end
         ST_REQ: begin
            if (data_sram_addr_ok) begin
               if (flush) begin
                  state_d   = ST_IDLE;
                  discard_d = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
               if (!data_sram_data_ok) discard_d = 1'b1;
            end else if (data_sram_data_ok) begin
               if (wb_allow_in) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d     = ST_DONE;
                  rdata_buf_d = data_sram_rdata;
               end
            end
         end
         ST_DONE: begin
            if (wb_allow_in || flush) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         discard_q   <= 1'b0;
         rdata_buf_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         rdata_buf_q <= rdata_buf_d;
      end
   end

   always_comb begin
      data_sram_wstrb = 4'b0000;
      case (mem_op)
         OP_ST_B: data_sram_wstrb = 4'b0001 << addr[1:0];
         OP_ST_H: data_sram_wstrb = addr[1] ? 4'b1100 : 4'b0011;
         OP_ST_W: data_sram_wstrb = 4'b1111;
         default: data_sram_wstrb = 4'b0000;
      endcase
   end

   assign data_sram_req   = !reset && (issue || (state_q == ST_REQ));
   assign data_sram_wr    = mem_op[2];
   assign data_sram_size  = mem_op[1:0];
   assign data_sram_addr  = addr;
   assign data_sram_wdata = wdata;

   assign ms_ready_go = !access_needed
                     || ((state_q == ST_WAIT) && data_sram_data_ok && !discard_q)
                     || (state_q == ST_DONE);
   assign ms_rdata    = (state_q == ST_DONE) ? rdata_buf_q : data_sram_rdata;

endmodule
